// File: rtl/cp80_pkg.sv
// cp80_pkg: shared defaults, ASCII tail bytes and UART frame state encoding
package cp80_pkg;
  localparam int PW_BYTES_DEF = 10;
  localparam int CLKS_PER_BIT_DEF = 434;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer; start may be asserted in the final stop cycle for gapless bytes
module uart_tx_byte
  import cp80_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       done
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
  tx_state_t state;
  logic [BW-1:0] baud;
  logic [2:0] bit_cnt;
  logic [7:0] sh;
  logic tick;
  assign tick = baud == LAST;
  assign done = state == STOP && tick;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      sh <= '0;
      txd <= 1'b1;
    end else if (start) begin
      state <= START;
      baud <= '0;
      bit_cnt <= '0;
      sh <= data;
      txd <= 1'b0;
    end else if (state != IDLE) begin
      baud <= tick ? '0 : baud + 1'b1;
      if (tick) begin
        if (state == START) begin
          state <= DATA;
          txd <= sh[0];
          sh <= {1'b0, sh[7:1]};
        end else if (state == DATA) begin
          if (bit_cnt == 3'd7) begin
            state <= STOP;
            txd <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            txd <= sh[0];
            sh <= {1'b0, sh[7:1]};
          end
        end else begin
          state <= IDLE;
          txd <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/result_uart_tx.sv
// result_uart_tx: buffers one password and streams it MSB byte first over UART 8N1
// Define CRLF_EN to append CR LF after the password bytes.
module result_uart_tx
  import cp80_pkg::*;
#(
  parameter int PW_BYTES     = PW_BYTES_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pw_valid,
  input  logic [PW_BYTES*8-1:0] pw_data,
  output logic                  pw_ready,
  output logic                  txd,
  output logic                  busy
);
`ifdef CRLF_EN
  localparam int NBYTES = PW_BYTES + 2;
`else
  localparam int NBYTES = PW_BYTES;
`endif
  localparam int IW = $clog2(PW_BYTES + 2);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
  logic [PW_BYTES*8-1:0] pw_buf;
  logic [IW-1:0] byte_idx;
  logic accept, done, more, start;
  logic [7:0] tx_byte;
  assign accept = pw_valid & pw_ready;
  assign more = busy && done && byte_idx != LAST_IDX;
  assign start = accept | more;
  // first byte bypasses the buffer so the start bit leaves one cycle after accept
`ifdef CRLF_EN
  assign tx_byte = accept ? pw_data[PW_BYTES*8-1 -: 8] :
                   byte_idx < IW'(PW_BYTES - 1) ? pw_buf[PW_BYTES*8-1 -: 8] :
                   byte_idx == IW'(PW_BYTES - 1) ? ASCII_CR : ASCII_LF;
`else
  assign tx_byte = accept ? pw_data[PW_BYTES*8-1 -: 8] : pw_buf[PW_BYTES*8-1 -: 8];
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pw_buf <= '0;
      byte_idx <= '0;
      busy <= 1'b0;
      pw_ready <= 1'b1;
    end else if (accept) begin
      pw_buf <= pw_data << 8;
      byte_idx <= '0;
      busy <= 1'b1;
      pw_ready <= 1'b0;
    end else if (busy && done) begin
      if (byte_idx == LAST_IDX) begin
        byte_idx <= '0;
        busy <= 1'b0;
        pw_ready <= 1'b1;
      end else begin
        byte_idx <= byte_idx + 1'b1;
        pw_buf <= pw_buf << 8;
      end
    end
  end
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .data(tx_byte),
    .txd(txd),
    .done(done)
  );
endmodule

// File: tb/tb_result_uart_tx.sv
// tb_result_uart_tx: randomized frames checked against a per-cycle UART line model
module tb_result_uart_tx;
  localparam int CPB = 4;
  localparam int NPW = 10;
`ifdef CRLF_EN
  localparam int NB = NPW + 2;
`else
  localparam int NB = NPW;
`endif
  localparam int FRAME = NB * 10 * CPB;
  localparam int NS = FRAME + 20;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pw_valid = 1'b0;
  logic [79:0] pw_data = '0;
  logic pw_ready, txd, busy;
  int passed = 0;
  int total = 0;
  logic s_txd [NS];
  logic s_busy [NS];
  logic s_rdy [NS];
  logic [7:0] eb [NB];

  result_uart_tx #(.PW_BYTES(NPW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pw_valid(pw_valid),
    .pw_data(pw_data),
    .pw_ready(pw_ready),
    .txd(txd),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] rnd80();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  task automatic load_model(input logic [79:0] d);
    for (int k = 0; k < NB; k++)
      eb[k] = k < NPW ? d[79-8*k -: 8] : (k == NPW ? 8'h0D : 8'h0A);
  endtask

  // line level at cycle i after accept: start 0, 8 data bits LSB first, stop 1
  function automatic logic exp_txd(input int i);
    int pos;
    if (i >= FRAME) return 1'b1;
    pos = (i % (10 * CPB)) / CPB;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return eb[i / (10 * CPB)][pos-1];
  endfunction

  task automatic offer(input logic [79:0] d, input string name);
    @(negedge clk);
    total++;
    if (pw_ready !== 1'b1) $display("FAIL %s ready_before: got %b want 1", name, pw_ready);
    else passed++;
    total++;
    if (txd !== 1'b1) $display("FAIL %s idle_txd: got %b want 1", name, txd);
    else passed++;
    pw_valid = 1'b1;
    pw_data = d;
    load_model(d);
  endtask

  task automatic capture(input int pulse_at);
    for (int i = 0; i < NS; i++) begin
      @(negedge clk);
      s_txd[i] = txd;
      s_busy[i] = busy;
      s_rdy[i] = pw_ready;
      if (i == 0) begin
        pw_valid = 1'b0;
        pw_data = rnd80();
      end
      if (i == pulse_at) begin
        pw_valid = 1'b1;
        pw_data = rnd80();
      end
      if (i == pulse_at + 1) pw_valid = 1'b0;
    end
  endtask

  task automatic verify(input string name);
    int bad_t = 0;
    int bad_b = 0;
    int nbusy = 0;
    logic [7:0] v;
    for (int i = 0; i < NS; i++) begin
      if (s_txd[i] !== exp_txd(i)) bad_t++;
      if (s_busy[i] !== logic'(i < FRAME)) bad_b++;
      if (s_busy[i] === 1'b1) nbusy++;
    end
    total++;
    if (bad_t != 0) $display("FAIL %s txd_wave: got %0d bad cycles want 0", name, bad_t);
    else passed++;
    total++;
    if (bad_b != 0) $display("FAIL %s busy_wave: got %0d bad cycles want 0", name, bad_b);
    else passed++;
    total++;
    if (nbusy != FRAME) $display("FAIL %s busy_len: got %0d want %0d", name, nbusy, FRAME);
    else passed++;
    total++;
    if (s_rdy[FRAME-1] !== 1'b0 || s_rdy[FRAME] !== 1'b1)
      $display("FAIL %s ready_edge: got %b%b want 01", name, s_rdy[FRAME-1], s_rdy[FRAME]);
    else passed++;
    for (int k = 0; k < NB; k++) begin
      for (int b = 0; b < 8; b++) v[b] = s_txd[k*10*CPB + CPB*(b+1) + CPB/2];
      total++;
      if (v !== eb[k]) $display("FAIL %s byte%0d: got %h want %h", name, k, v, eb[k]);
      else passed++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (txd !== 1'b1 || busy !== 1'b0) $display("FAIL reset_hold: got txd=%b busy=%b want 1 0", txd, busy);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (pw_ready !== 1'b1 || busy !== 1'b0 || txd !== 1'b1)
      $display("FAIL reset_release: got ready=%b busy=%b txd=%b want 1 0 1", pw_ready, busy, txd);
    else passed++;
  endtask

  task automatic test_single();
    offer("PASSWORD80", "single");
    capture(-1);
    verify("single");
  endtask

  task automatic test_bit_timing();
    int bad = 0;
    offer({8'h55, 72'(rnd80())}, "timing");
    capture(-1);
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < CPB; c++)
        if (s_txd[b*CPB + c] !== logic'(b % 2)) bad++;
    total++;
    if (bad != 0) $display("FAIL timing_0x55: got %0d bad cycles want 0", bad);
    else passed++;
    verify("timing");
  endtask

  task automatic test_ignore();
    offer(rnd80(), "ignore");
    capture(100);
    total++;
    if (s_rdy[100] !== 1'b0) $display("FAIL ignore_ready: got %b want 0", s_rdy[100]);
    else passed++;
    verify("ignore");
  endtask

  task automatic test_reset_mid();
    offer(rnd80(), "rstmid");
    for (int i = 0; i <= 3*10*CPB + 1; i++) begin
      @(negedge clk);
      if (i == 0) pw_valid = 1'b0;
    end
    total++;
    if (txd !== 1'b0) $display("FAIL rstmid_pre: got %b want 0", txd);
    else passed++;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (txd !== 1'b1 || busy !== 1'b0) $display("FAIL rstmid_async: got txd=%b busy=%b want 1 0", txd, busy);
    else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    offer(rnd80(), "rstmid_after");
    capture(-1);
    verify("rstmid_after");
  endtask

  task automatic test_back_to_back();
    int nbusy = 0;
    logic [79:0] d2;
    d2 = rnd80();
    offer(rnd80(), "b2b");
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (busy === 1'b1) nbusy++;
      if (i == 0) pw_valid = 1'b0;
      if (i == FRAME - 1) begin
        pw_valid = 1'b1;
        pw_data = d2;
      end
    end
    total++;
    if (nbusy != FRAME) $display("FAIL b2b_busy1: got %0d want %0d", nbusy, FRAME);
    else passed++;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || pw_ready !== 1'b1 || txd !== 1'b1)
      $display("FAIL b2b_gap: got busy=%b ready=%b txd=%b want 0 1 1", busy, pw_ready, txd);
    else passed++;
    load_model(d2);
    capture(-1);
    verify("b2b_second");
  endtask

  initial begin
    test_reset();
    test_single();
    test_bit_timing();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    repeat (4) begin
      offer(rnd80(), "random");
      capture(-1);
      verify("random");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
